// File: rtl/tlv5638_frame_tx_pkg.sv
// Shared constants and types for the TLV5638 frame transmitter.
// TLV5638_REF_INIT_EN adds the INIT state used for the reference-setup word.
package tlv5638_frame_tx_pkg;

   // R1/R0 register-select pairs of the TLV5638 control nibble
   localparam logic [1:0] CTRL_BUF   = 2'b01;
   localparam logic [1:0] CTRL_A_UPD = 2'b10;
   localparam logic [1:0] CTRL_REG   = 2'b11;

   localparam logic [1:0] REF_EXT    = 2'b00;
   localparam logic [1:0] REF_1V024  = 2'b01;
   localparam logic [1:0] REF_2V048  = 2'b10;
   localparam logic [1:0] REF_EXT_B  = 2'b11;

   typedef enum logic [2:0] {
`ifdef TLV5638_REF_INIT_EN
      ST_INIT,
`endif
      ST_IDLE,
      ST_CS_SETUP,
      ST_SHIFT,
      ST_CS_HOLD,
      ST_GAP,
      ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      W_INIT,
      W_B,
      W_A
   } word_e;

   // Control nibble is {R1, SPD, PWR=0, R0}
   function automatic logic [15:0] ctrl_word(input logic [1:0] r1r0,
                                             input logic       spd,
                                             input logic [11:0] data);
      return {r1r0[1], spd, 1'b0, r1r0[0], data};
   endfunction

endpackage

// File: rtl/tlv5638_frame_tx_sync_edge_det.sv
// Two-flop synchroniser with a rising-edge pulse, for divided clocks that are
// asynchronous to clk (sample clock, 1 kHz marker).
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic edge_pulse
);

   logic s1_q, s2_q, prev_q;
   logic s1_d, s2_d, prev_d;

   always_comb begin
      s1_d   = async_in;
      s2_d   = s1_q;
      prev_d = s2_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         prev_q <= prev_d;
      end
   end

   assign edge_pulse = s2_q & ~prev_q;

endmodule

// File: rtl/tlv5638_frame_tx.sv
// Serialises one {buffer B, write A + update B} word pair per sample-clock edge
// to a TLV5638 DAC. Define TLV5638_REF_INIT_EN to send a reference-setup word after reset.
module tlv5638_frame_tx
   import tlv5638_frame_tx_pkg::*;
#(
   parameter int         SCLK_HALF = 4,
   parameter int         CS_GAP    = 4,
   parameter logic       SPD       = 1'b1,
   parameter logic [1:0] REF_SEL   = REF_2V048
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sample_clk,
   input  logic [11:0] data_a,
   input  logic [11:0] data_b,
   output logic        dac_cs_n,
   output logic        dac_sclk,
   output logic        dac_din,
   output logic        busy,
   output logic        frame_done,
   output logic        overrun
);

   localparam int CNT_MAX = (SCLK_HALF > CS_GAP) ? SCLK_HALF : CS_GAP;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(SCLK_HALF - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((CS_GAP > 1) ? CS_GAP - 2 : 0);

`ifdef TLV5638_REF_INIT_EN
   localparam state_e     RST_STATE = ST_INIT;
   localparam logic [15:0] INIT_WORD = ctrl_word(CTRL_REG, SPD, {10'b0, REF_SEL});
`else
   localparam state_e     RST_STATE = ST_IDLE;
`endif

   logic edge_det;

   sync_edge_det u_sync (
      .clk        (clk),
      .rst        (rst),
      .async_in   (sample_clk),
      .edge_pulse (edge_det)
   );

   state_e           state_q, state_d;
   word_e            word_q, word_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       bit_q, bit_d;
   logic [15:0]      sh_q, sh_d;
   logic [11:0]      hold_a_q, hold_a_d;
   logic             cs_n_q, cs_n_d;
   logic             sclk_q, sclk_d;
   logic             din_q, din_d;
   logic             busy_q, busy_d;
   logic             frame_done_q, frame_done_d;
   logic             overrun_q, overrun_d;
   logic             gap_done;
   logic [15:0]      word1;

   always_comb begin
      state_d      = state_q;
      word_d       = word_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      sh_d         = sh_q;
      hold_a_d     = hold_a_q;
      cs_n_d       = cs_n_q;
      sclk_d       = sclk_q;
      din_d        = din_q;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      overrun_d    = overrun_q | (edge_det && (state_q != ST_IDLE));
      gap_done     = 1'b0;
      word1        = ctrl_word(CTRL_A_UPD, SPD, hold_a_q);

      unique case (state_q)
`ifdef TLV5638_REF_INIT_EN
         ST_INIT: begin
            state_d = ST_CS_SETUP;
            word_d  = W_INIT;
            sh_d    = INIT_WORD;
            din_d   = INIT_WORD[15];
            cs_n_d  = 1'b0;
            busy_d  = 1'b1;
            cnt_d   = HALF_LOAD;
         end
`endif
         ST_IDLE: begin
            if (edge_det) begin
               state_d  = ST_CS_SETUP;
               word_d   = W_B;
               hold_a_d = data_a;
               sh_d     = ctrl_word(CTRL_BUF, SPD, data_b);
               din_d    = 1'b0;
               cs_n_d   = 1'b0;
               busy_d   = 1'b1;
               cnt_d    = HALF_LOAD;
            end
         end
         ST_CS_SETUP: begin
            if (cnt_q == '0) begin
               state_d = ST_SHIFT;
               sclk_d  = 1'b0;
               bit_d   = 4'd15;
               cnt_d   = HALF_LOAD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_SHIFT: begin
            // sclk_q doubles as the phase flag: low phase ends in a rise that advances DIN
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (!sclk_q) begin
               sclk_d = 1'b1;
               din_d  = sh_q[14];
               sh_d   = {sh_q[14:0], 1'b0};
               cnt_d  = HALF_LOAD;
            end else if (bit_q == 4'd0) begin
               state_d = ST_CS_HOLD;
               cs_n_d  = 1'b1;
               din_d   = 1'b0;
            end else begin
               sclk_d = 1'b0;
               bit_d  = bit_q - 1'b1;
               cnt_d  = HALF_LOAD;
            end
         end
         ST_CS_HOLD: begin
            if (CS_GAP > 1) begin
               state_d = ST_GAP;
               cnt_d   = GAP_LOAD;
            end else begin
               gap_done = 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) gap_done = 1'b1;
            else             cnt_d = cnt_q - 1'b1;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (gap_done) begin
         unique case (word_q)
            W_B: begin
               state_d = ST_CS_SETUP;
               word_d  = W_A;
               sh_d    = word1;
               din_d   = word1[15];
               cs_n_d  = 1'b0;
               cnt_d   = HALF_LOAD;
            end
            W_A: begin
               state_d      = ST_DONE;
               busy_d       = 1'b0;
               frame_done_d = 1'b1;
            end
            default: begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end

      // word0 MSB is presented once the word is latched into the shift register
      if (state_q == ST_IDLE && edge_det) din_d = sh_d[15];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= RST_STATE;
         word_q       <= W_B;
         cnt_q        <= '0;
         bit_q        <= '0;
         sh_q         <= '0;
         hold_a_q     <= '0;
         cs_n_q       <= 1'b1;
         sclk_q       <= 1'b1;
         din_q        <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_q       <= word_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         sh_q         <= sh_d;
         hold_a_q     <= hold_a_d;
         cs_n_q       <= cs_n_d;
         sclk_q       <= sclk_d;
         din_q        <= din_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
      end
   end

   assign dac_cs_n   = cs_n_q;
   assign dac_sclk   = sclk_q;
   assign dac_din    = din_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign overrun    = overrun_q;

endmodule
